// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity frame receiver slice.
//   rx_state_e : receiver FSM states (IDLE, DATA, PAR, STOP)
//   PAR_EVEN / PAR_ODD : values for the PARITY_ODD parameter
package parity_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_e;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Output bus of the parity frame receiver: received word, error flags and
// the valid/ready handshake.
//   dout       : received data word (DBIT bits)
//   dout_valid : dout and error flags are valid
//   dout_ready : consumer accepts when dout_valid && dout_ready
//   parity_err : parity mismatch, qualified by dout_valid
//   frame_err  : stop bit sampled as 0, qualified by dout_valid
// master = receiver side, slave = consumer side.
interface parity_frame_rx_if #(
    parameter int unsigned DBIT = 8
);
    logic [DBIT-1:0] dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            parity_err;
    logic            frame_err;

    modport master (
        output dout,
        output dout_valid,
        output parity_err,
        output frame_err,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  parity_err,
        input  frame_err,
        output dout_ready
    );
endinterface

// File: rtl/parity_frame_rx_frame_out_reg.sv
// One-entry valid/ready holding register with overrun detection.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : a completed payload is offered this cycle
//   load_data    : payload offered with load
//   ready        : consumer accepts the held entry
//   data, valid  : held payload and its valid flag
//   overrun      : sticky, set when a load is dropped because the slot was
//                  full and not being accepted; cleared only by reset
module frame_out_reg #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);
    logic slot_free;

    // An entry being accepted this cycle frees the slot for a same-cycle load.
    assign slot_free = ~valid | ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && slot_free) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (load && !slot_free) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DBIT data bits LSB first, parity bit,
// stop bit, one bit per s_tick. Parity is accumulated as bits arrive.
//   clk, reset_n : clock, asynchronous active-low reset
//   s_tick       : bit-sample strobe; rx_in is sampled only when high
//   rx_in        : synchronized serial input, idle high
//   out_if       : word/error-flag output with valid/ready handshake
//   overrun      : sticky, a completed frame was dropped (slot full)
//   busy         : FSM is not in IDLE
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int unsigned DBIT       = 8,
    parameter bit          PARITY_ODD = PAR_EVEN
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_tick,
    input  logic                     rx_in,
    parity_frame_rx_if.master        out_if,
    output logic                     overrun,
    output logic                     busy
);
    localparam int unsigned CW = $clog2(DBIT + 1);

    rx_state_e       state_q, state_d;
    logic [DBIT-1:0] sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            par_q, par_d;
    logic            pe_q, pe_d;
    logic            load;
    logic [DBIT+1:0] load_data;
    logic [DBIT+1:0] out_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            pe_q    <= pe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        pe_d      = pe_q;
        load      = 1'b0;
        // Frame error is taken straight from the stop-bit sample; no flop needed.
        load_data = {sreg_q, pe_q, ~rx_in};
        if (s_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                DATA: begin
                    sreg_d = {rx_in, sreg_q[DBIT-1:1]};
                    par_d  = par_q ^ rx_in;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(DBIT - 1)) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    pe_d    = rx_in ^ par_q ^ PARITY_ODD;
                    state_d = STOP;
                end
                STOP: begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    frame_out_reg #(
        .WIDTH (DBIT + 2)
    ) u_out_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (load_data),
        .ready     (out_if.dout_ready),
        .data      (out_data),
        .valid     (out_if.dout_valid),
        .overrun   (overrun)
    );

    assign out_if.dout       = out_data[DBIT+1:2];
    assign out_if.parity_err = out_data[1];
    assign out_if.frame_err  = out_data[0];
    assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;
    localparam int unsigned DBIT = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic s_tick;
    logic rx_in;
    logic dout_ready;
    logic ovr_e, busy_e, ovr_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    parity_frame_rx_if #(.DBIT(DBIT)) if_e ();
    parity_frame_rx_if #(.DBIT(DBIT)) if_o ();

    assign if_e.dout_ready = dout_ready;
    assign if_o.dout_ready = dout_ready;

    parity_frame_rx #(.DBIT(DBIT), .PARITY_ODD(1'b0)) dut_e (
        .clk     (clk),
        .reset_n (reset_n),
        .s_tick  (s_tick),
        .rx_in   (rx_in),
        .out_if  (if_e),
        .overrun (ovr_e),
        .busy    (busy_e)
    );

    parity_frame_rx #(.DBIT(DBIT), .PARITY_ODD(1'b1)) dut_o (
        .clk     (clk),
        .reset_n (reset_n),
        .s_tick  (s_tick),
        .rx_in   (rx_in),
        .out_if  (if_o),
        .overrun (ovr_o),
        .busy    (busy_o)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: collect the sampled bits of a frame into a queue,
    // then derive word and flags arithmetically and place them in a one-slot
    // output buffer.
    bit              m_busy, m_valid, m_ovr, m_pe_e, m_pe_o, m_fe;
    logic [DBIT-1:0] m_data;
    bit              q[$];
    bit              m_done;
    logic [DBIT-1:0] w;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_valid = 0; m_ovr = 0;
            m_pe_e = 0; m_pe_o = 0; m_fe = 0; m_data = '0;
            q.delete();
        end else begin
            m_done = 0;
            if (s_tick) begin
                if (!m_busy) begin
                    if (!rx_in) m_busy = 1;
                end else begin
                    q.push_back(rx_in);
                    if (q.size() == DBIT + 2) begin
                        m_done = 1;
                        m_busy = 0;
                    end
                end
            end
            if (m_valid && dout_ready) m_valid = 0;
            if (m_done) begin
                for (int i = 0; i < DBIT; i++) w[i] = q[i];
                if (!m_valid) begin
                    m_valid = 1;
                    m_data  = w;
                    m_pe_e  = (^w) ^ q[DBIT];
                    m_pe_o  = ~((^w) ^ q[DBIT]);
                    m_fe    = ~q[DBIT+1];
                end else begin
                    m_ovr = 1;
                end
                q.delete();
            end
        end
    end

    always @(negedge clk) begin
        chk("valid_e", 16'(if_e.dout_valid), 16'(m_valid));
        chk("valid_o", 16'(if_o.dout_valid), 16'(m_valid));
        chk("overrun_e", 16'(ovr_e), 16'(m_ovr));
        chk("overrun_o", 16'(ovr_o), 16'(m_ovr));
        chk("busy_e", 16'(busy_e), 16'(m_busy));
        chk("busy_o", 16'(busy_o), 16'(m_busy));
        if (m_valid) begin
            chk("dout_e", 16'(if_e.dout), 16'(m_data));
            chk("dout_o", 16'(if_o.dout), 16'(m_data));
            chk("perr_e", 16'(if_e.parity_err), 16'(m_pe_e));
            chk("perr_o", 16'(if_o.parity_err), 16'(m_pe_o));
            chk("ferr_e", 16'(if_e.frame_err), 16'(m_fe));
            chk("ferr_o", 16'(if_o.frame_err), 16'(m_fe));
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in  = b;
        s_tick = 1'b1;
        @(posedge clk);
        #1;
        s_tick = 1'b0;
    endtask

    // Returns one time unit after the edge that samples the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                              input bit rdy_at_stop);
        send_bit(1'b0);
        gap(2);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            gap(2);
        end
        send_bit(pb);
        gap(2);
        if (rdy_at_stop) dout_ready = 1'b1;
        send_bit(sb);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        gap(2);
        reset_n = 1'b1;
        gap(1);
    endtask

    initial begin
        reset_n    = 1'b0;
        s_tick     = 1'b0;
        rx_in      = 1'b1;
        dout_ready = 1'b1;
        gap(2);
        reset_n = 1'b1;
        #1;
        chk("rst_dout", 16'(if_e.dout), 16'h0000);
        chk("rst_valid", 16'(if_e.dout_valid), 16'h0000);
        chk("rst_overrun", 16'(ovr_e), 16'h0000);
        chk("rst_busy", 16'(busy_e), 16'h0000);
        gap(2);

        // 0xA5, even parity bit 0, good stop, ready held high
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        chk("a5_dout", 16'(if_e.dout), 16'h00A5);
        chk("a5_valid", 16'(if_e.dout_valid), 16'h0001);
        chk("a5_perr", 16'(if_e.parity_err), 16'h0000);
        chk("a5_ferr", 16'(if_e.frame_err), 16'h0000);
        gap(1);
        chk("a5_valid_drop", 16'(if_e.dout_valid), 16'h0000);
        gap(2);

        // 0x07 with parity bit 0: wrong for even, right for odd
        send_frame(8'h07, 1'b0, 1'b1, 0);
        chk("07_dout", 16'(if_e.dout), 16'h0007);
        chk("07_perr_even", 16'(if_e.parity_err), 16'h0001);
        chk("07_perr_odd", 16'(if_o.parity_err), 16'h0000);
        chk("07_ferr", 16'(if_e.frame_err), 16'h0000);
        gap(2);

        // 0x3C with bad stop bit
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        chk("3c_dout", 16'(if_e.dout), 16'h003C);
        chk("3c_ferr", 16'(if_e.frame_err), 16'h0001);
        chk("3c_busy", 16'(busy_e), 16'h0000);
        rx_in = 1'b1;
        gap(2);

        // Overrun: consumer stalled across two frames
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0);
        gap(2);
        send_frame(8'h22, 1'b0, 1'b1, 0);
        chk("ovr_dout", 16'(if_e.dout), 16'h0011);
        chk("ovr_flag", 16'(ovr_e), 16'h0001);
        gap(2);
        dout_ready = 1'b1;
        gap(1);
        chk("ovr_valid_drop", 16'(if_e.dout_valid), 16'h0000);
        chk("ovr_sticky", 16'(ovr_e), 16'h0001);
        gap(2);

        // Accept and load in the same cycle
        do_reset();
        dout_ready = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1, 0);
        gap(2);
        send_frame(8'hAA, 1'b0, 1'b1, 1);
        chk("b2b_dout", 16'(if_e.dout), 16'h00AA);
        chk("b2b_valid", 16'(if_e.dout_valid), 16'h0001);
        chk("b2b_overrun", 16'(ovr_e), 16'h0000);
        gap(3);

        // Reset mid-frame, then a clean frame
        send_bit(1'b0);
        gap(2);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            gap(2);
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dout", 16'(if_e.dout), 16'h0000);
        chk("mid_rst_valid", 16'(if_e.dout_valid), 16'h0000);
        chk("mid_rst_busy", 16'(busy_e), 16'h0000);
        chk("mid_rst_overrun", 16'(ovr_e), 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        gap(2);
        send_frame(8'h81, 1'b0, 1'b1, 0);
        chk("81_dout", 16'(if_e.dout), 16'h0081);
        chk("81_valid", 16'(if_e.dout_valid), 16'h0001);
        chk("81_perr", 16'(if_e.parity_err), 16'h0000);
        chk("81_ferr", 16'(if_e.frame_err), 16'h0000);
        gap(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial frame receiver that deserializes one bit per sample strobe into a DBIT-wide word.
- Keeps a running XOR parity of the data bits as they arrive, so parity comes for free with no separate reduction tree.
- Checks the received parity bit and stop bit, and presents the word plus error flags on a one-entry valid/ready output register.
- Sits upstream of the byte-level consumers and the parity reduction stage; it feeds them assembled words.

Parameters:
- DBIT, 8: number of data bits per frame, LSB first. Legal range 2..16.
- PARITY_ODD, 0: 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- s_tick, input, 1: bit-sample strobe, one clk wide. rx_in is sampled only when s_tick=1.
- rx_in, input, 1: serial data, already synchronized. Idle level is 1.
- dout, output, DBIT: received data word.
- dout_valid, output, 1: dout and the error flags are valid.
- dout_ready, input, 1: consumer accepts the word when dout_valid and dout_ready are both 1.
- parity_err, output, 1: received parity bit did not match computed parity. Qualified by dout_valid.
- frame_err, output, 1: stop bit sampled as 0. Qualified by dout_valid.
- overrun, output, 1: sticky. Set when a completed frame is dropped because the output register was still full. Cleared only by reset.
- busy, output, 1: FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, on reset_n=0):
  - FSM goes to IDLE.
  - Shift register, bit counter and running parity clear to 0.
  - dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Reset asserted mid-frame abandons the frame; no partial word is ever output.
- State machine (advances only on s_tick=1; with s_tick=0 all state holds):
  - IDLE: if rx_in=0, go to DATA; clear counter and parity.
  - DATA: shift register <= {rx_in, sreg[DBIT-1:1]}; parity <= parity ^ rx_in; counter increments. After the DBIT-th bit, go to PAR.
  - PAR: latch pe = rx_in ^ parity ^ PARITY_ODD (1 means error). Go to STOP.
  - STOP: latch fe = ~rx_in. Attempt the output load (next bullet). Go to IDLE.
- Output load:
  - Slot free (dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle): on the next edge load dout, parity_err and frame_err, and set dout_valid=1.
  - Slot full with no accept that cycle: drop the frame, set overrun=1, leave the held output untouched.
- Latency: dout_valid rises on the clk edge after the cycle in which the stop-bit s_tick is sampled.
- Handshake:
  - dout, the error flags and dout_valid hold stable while dout_valid=1 and dout_ready=0.
  - Accept without a new load clears dout_valid on the next edge.
  - Accept and load in the same cycle: the load wins and dout_valid stays 1 with the new data.
- Simultaneous events:
  - A start bit sampled in the same s_tick as a stop-bit completion cannot occur; each tick is consumed by exactly one state.
  - rx_in=0 in IDLE starts a frame immediately. There is no glitch filter; filtering is upstream's job.
- Error frames (parity_err or frame_err set) are still delivered; the consumer decides whether to discard.
- Counter width is clog2(DBIT+1). Parity is a single XOR flop, never a reduction tree.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, DATA, PAR, STOP;
  - parity mode constants: PAR_EVEN=0, PAR_ODD=1.
- Natural sub-module: frame_out_reg, the one-entry valid/ready holding register with overrun detection. Parameterized by width; payload is DBIT+2 bits (dout, parity_err, frame_err).
- The FSM and shift path stay in parity_frame_rx.

Test Plan:
- Frame 0xA5, DBIT=8, even parity, parity bit 0, stop bit 1, dout_ready held at 1 -> dout=0xA5, parity_err=0, frame_err=0; dout_valid high for 1 clk, one edge after the stop tick.
- Frame 0x07, even parity, parity bit 0 (wrong) -> dout=0x07, parity_err=1, frame_err=0. Rerun with PARITY_ODD=1 and parity bit 0 -> parity_err=0.
- Frame 0x3C, stop bit 0 -> dout=0x3C, frame_err=1, FSM back in IDLE after that tick.
- dout_ready=0; send 0x11, then 0x22 -> dout stays 0x11, overrun=1 after the 0x22 stop tick. Raising dout_ready consumes 0x11 and dout_valid drops; overrun stays 1.
- Back-to-back frames 0x55 then 0xAA; dout_ready rises in the exact cycle the 0xAA load occurs -> 0x55 accepted, dout=0xAA with dout_valid continuously 1, overrun=0.
- reset_n pulsed low for 1 clk after 4 data bits of 0xFF -> all outputs 0 immediately. The next full frame 0x81 is received correctly with no residue.
